// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, fetch FSM states and the fetch buffer entry type
// used by the instruction-fetch sequencer and its decode buffer.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch_entry_t between fetch and decode.
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset
//   push_i, wdata_i - write an entry at the tail (ignored when full without pop)
//   pop_i           - remove the head entry (ignored when empty)
//   flush_i         - discard all entries; overrides push and pop
//   rdata_o         - head entry (registered storage, no comb path from inputs)
//   count_o         - number of stored entries
//   full_o, empty_o - occupancy flags
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t         mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          cnt_q, cnt_d;
    logic                 do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i && do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer. Owns the fetch PC, addresses the
// combinational instruction memory, buffers {pc, instr} for decode and handles
// redirects, stalls and misaligned / out-of-range fetch faults.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   enable              - 1 = fetch allowed; 0 = hold PC, buffer keeps draining
//   im_addr / im_cmd    - instruction memory address (fetch PC) / returned word
//   redirect_valid/_pc  - taken branch/jump: flush buffer, load new fetch PC
//   out_valid/out_ready - decode handshake on the buffer head
//   out_instr, out_pc, out_pc_plus4 - head entry (zero while out_valid=0)
//   fault               - sticky fetch fault, cleared only by redirect/reset
//   icount              - count of instructions accepted by decode
module ifetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IM_SIZE    = 128,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] im_addr,
    input  logic [31:0] im_cmd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault,
    output logic [31:0] icount
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    // 33 bits so a large IM_SIZE cannot wrap the limit.
    localparam logic [32:0] IM_BYTES = 33'(IM_SIZE) << 2;

    fetch_state_e   state_q, state_d;
    logic [31:0]    fpc_q, fpc_d;
    logic           fault_q, fault_d;
    logic [31:0]    icount_q, icount_d;

    logic           fifo_push, fifo_pop, fifo_flush;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   fifo_wdata, fifo_head;
    logic           handshake, fetch_bad;

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid  = (fifo_count != '0);
    assign handshake  = out_ready && !fifo_empty;
    assign fetch_bad  = (fpc_q[1:0] != 2'b00) || ({1'b0, fpc_q} >= IM_BYTES);
    assign fifo_wdata = '{pc: fpc_q, instr: im_cmd};

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        fault_d    = fault_q;
        icount_d   = icount_q;
        fifo_push  = 1'b0;
        fifo_pop   = handshake;
        fifo_flush = 1'b0;
        if (redirect_valid) begin
            // A redirect drops the head even if decode is taking it this cycle.
            fifo_flush = 1'b1;
            fifo_pop   = 1'b0;
            fpc_d      = redirect_pc;
            fault_d    = 1'b0;
            state_d    = FETCH;
        end else begin
            if (handshake) icount_d = icount_q + 32'd1;
            case (state_q)
                FETCH: begin
                    if (fetch_bad) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else if (enable && (!fifo_full || handshake)) begin
                        fifo_push = 1'b1;
                        fpc_d     = fpc_q + 32'd4;
                    end
                end
                FAULT: begin
                    // Wait for redirect or reset.
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            fpc_q    <= RESET_PC;
            fault_q  <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            fault_q  <= fault_d;
            icount_q <= icount_d;
        end
    end

    assign im_addr      = fpc_q;
    assign fault        = fault_q;
    assign icount       = icount_q;
    assign out_instr    = out_valid ? fifo_head.instr : '0;
    assign out_pc       = out_valid ? fifo_head.pc : '0;
    assign out_pc_plus4 = out_valid ? (fifo_head.pc + 32'd4) : '0;

endmodule
